alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue/retire stage wrapped around the combinational `alu`. It accepts operand/opcode commands over a valid/ready handshake and drives the ALU inputs from a register. It captures the ALU result and flags one cycle later into an output register with its own valid/ready handshake. It also keeps sticky overflow/carry status and a retired-result counter for software visibility.

## Interface
- `WIDTH`, 8, operand/result width; must match the attached `alu`
- `CNT_W`, 16, width of retired-result counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  command valid
- `in_ready`  out  1  stage can accept a command this cycle
- `in_a`, `in_b`  in  WIDTH  operands
- `in_op`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101–111 reserved
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  3  registered opcode to the ALU
- `alu_y`  in  WIDTH  ALU result
- `alu_overflow`, `alu_carry`, `alu_zero`, `alu_negative`  in  1  ALU flags
- `out_valid`  out  1  result register holds a result
- `out_ready`  in  1  consumer accepts the result
- `out_y`  out  WIDTH  registered result
- `out_flags`  out  4  {overflow, carry, zero, negative}, registered
- `out_illegal`  out  1  result came from a reserved opcode
- `sticky_ovf`, `sticky_carry`  out  1  accumulated flags since the last clear
- `sticky_clr`  in  1  clears both sticky bits
- `result_count`  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W

## Operation
- The pipeline has two register stages:
  - S1 (issue): `s1_valid`, `alu_a`, `alu_b`, `alu_op`.
  - S2 (result): `out_valid`, `out_y`, `out_flags`, `out_illegal`.
- Advance conditions:
  - `s2_free = !out_valid || out_ready`.
  - `s1_adv = s1_valid && s2_free`.
  - `in_ready = !s1_valid || s2_free` (combinational; no dependence on `in_valid`).
- Input handshake: `in_valid && in_ready` at an edge loads S1 from `in_*` and sets `s1_valid`.
- If S1 advances with no new command, `s1_valid` clears. S1 operand registers hold their value when not loaded.
- On `s1_adv`, S2 loads `alu_y` and the four flags.
  - `out_illegal` is set to (`alu_op` ≥ 3'b101).
  - `out_valid` sets.
- Without `s1_adv`, an output handshake (`out_valid && out_ready`) clears `out_valid`.
- Reserved opcodes still flow through the pipeline. `out_y` and `out_flags` take whatever the ALU produces, and `out_illegal` = 1.
- Sticky bits:
  - On `s1_adv` with a legal opcode, `sticky_ovf |= alu_overflow` and `sticky_carry |= alu_carry`.
  - `sticky_clr` zeroes both bits.
  - If a clear and a set occur in the same cycle, set wins: the bit ends at 1.
- `result_count` increments by 1 on each output handshake and wraps from all-ones to 0.
- While `out_valid && !out_ready`, `out_y`, `out_flags` and `out_illegal` hold stable.

## Timing
- Reset (synchronous, `rst` high at an edge) clears every state register to 0: `s1_valid`, `alu_a`, `alu_b`, `alu_op`, `out_valid`, `out_y`, `out_flags`, `out_illegal`, `sticky_ovf`, `sticky_carry`, `result_count`.
  - After reset, `in_ready` = 1.
  - While `rst` is high, handshakes are ignored and no state updates.
  - In-flight commands are discarded.
- Latency:
  - A command accepted at edge k appears on `alu_*` after edge k.
  - Its result is on `out_*` with `out_valid` = 1 after edge k+1, provided S2 was free at k+1.
- Throughput: with `out_ready` held at 1, the stage accepts one command per cycle with no bubbles.
- Backpressure:
  - With `out_ready` = 0 and both stages full, `in_ready` = 0.
  - The stage holds at most 2 commands.
  - No command is dropped or duplicated.
- Simultaneous events:
  - If S2 drains and S1 advances in the same edge, S2 takes the new result and `out_valid` stays 1.
  - If S1 advances and a new command is accepted in the same edge, S1 reloads and `s1_valid` stays 1.
- The ALU sees `alu_*` for a full cycle before S2 samples, so the ALU's combinational path is one clock.

## Test plan
- Reset, then `out_ready` = 1 and ADD a=1, b=2 accepted at edge k → `out_valid` after k+1, `out_y`=3, `out_flags`=0000, `out_illegal`=0, `result_count`=1 after the handshake.
- Back-to-back with `out_ready` = 1: SUB 10−3, AND 0xFF&0x00, OR 0xFF|0x00, XOR 0xAA^0xFF → `out_y` = 7, 0x00 (zero=1), 0xFF (negative=1), 0x55 in consecutive cycles; `in_ready` stays 1 throughout.
- ADD 0x7F+0x01 → `out_y`=0x80, overflow=1, negative=1, `sticky_ovf`=1. Then ADD 0xFF+0x01 → `out_y`=0x00, carry=1, zero=1, `sticky_carry`=1. Pulse `sticky_clr` on the same cycle as a new carry-producing `s1_adv` → `sticky_carry` stays 1. A lone clear → both sticky bits 0.
- `out_ready` = 0 while offering 3 commands → 2 accepted, `in_ready` = 0, `out_y` stable. Release `out_ready` → all 3 results emerge in order, none lost.
- Opcode 3'b110 → `out_illegal` = 1 and sticky bits unchanged, even if the ALU flags are 1.
- Assert `rst` with both stages full → next cycle `out_valid` = 0, `in_ready` = 1, `result_count` = 0, sticky bits 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around a combinational ALU: S1 drives the ALU, S2 captures its result a cycle later.
// Valid/ready on both sides; one command per cycle when unstalled, at most two held under output backpressure.
module alu_issue_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic             sticky_ovf,
  output logic             sticky_carry,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] result_count
);

  localparam logic [2:0] OP_FIRST_RSVD = 3'b101;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_carry_q, sticky_carry_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic s2_free, s1_adv, in_fire, out_fire, op_legal;

  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
    op_legal = (op_q < OP_FIRST_RSVD);
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    out_valid_d    = out_valid_q;
    y_d            = y_q;
    flags_d        = flags_q;
    illegal_d      = illegal_q;
    sticky_ovf_d   = sticky_ovf_q;
    sticky_carry_d = sticky_carry_q;
    count_d        = count_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
      op_d       = in_op;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      y_d         = alu_y;
      flags_d     = {alu_overflow, alu_carry, alu_zero, alu_negative};
      illegal_d   = !op_legal;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // Clear first so a same-cycle set from a legal result wins.
    if (sticky_clr) begin
      sticky_ovf_d   = 1'b0;
      sticky_carry_d = 1'b0;
    end
    if (s1_adv && op_legal) begin
      sticky_ovf_d   = sticky_ovf_d | alu_overflow;
      sticky_carry_d = sticky_carry_d | alu_carry;
    end

    if (out_fire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      out_valid_q    <= 1'b0;
      y_q            <= '0;
      flags_q        <= '0;
      illegal_q      <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
      count_q        <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      out_valid_q    <= out_valid_d;
      y_q            <= y_d;
      flags_q        <= flags_d;
      illegal_q      <= illegal_d;
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_carry_q <= sticky_carry_d;
      count_q        <= count_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign out_valid    = out_valid_q;
  assign out_y        = y_q;
  assign out_flags    = flags_q;
  assign out_illegal  = illegal_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_carry = sticky_carry_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU plus a transaction-queue reference model,
// directed scenarios followed by a randomized phase.
module tb_alu_issue_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_op;
  logic             alu_overflow, alu_carry, alu_zero, alu_negative;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic             out_illegal, sticky_ovf, sticky_carry, sticky_clr;
  logic [CNT_W-1:0] result_count;

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
    .out_illegal(out_illegal), .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry),
    .sticky_clr(sticky_clr), .result_count(result_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, carry, zero, negative, y}. Reserved ops pass a and raise ovf/carry.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] y;
    logic       v, c;
    s = '0; y = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin y = a - b; c = (a < b); v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      default: begin y = a; c = 1'b1; v = 1'b1; end
    endcase
    return {v, c, (y == 8'h00), y[7], y};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_negative, alu_y} = alu_ref(alu_a, alu_b, alu_op);

  typedef struct {
    logic [7:0] y;
    logic [3:0] f;
    logic       ill;
    int         id;
    int         edge_acc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          edge_n = 0;
  int          next_id = 0;
  int          last_merged = -1;
  int          popped = 0;
  logic        m_sovf = 1'b0, m_scar = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic vis;
    vis = (q.size() > 0) && (edge_n > q[0].edge_acc);
    chk("out_valid", out_valid, vis);
    if (vis) begin
      chk("out_y", out_y, q[0].y);
      chk("out_flags", out_flags, q[0].f);
      chk("out_illegal", out_illegal, q[0].ill);
    end
    chk("sticky_ovf", sticky_ovf, m_sovf);
    chk("sticky_carry", sticky_carry, m_scar);
    chk("result_count", result_count, m_cnt);
  endtask

  // Called at a falling edge: presents inputs, lets one rising edge pass, updates the model, checks at the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic ordy, input logic clr);
    logic       fire_in, fire_out;
    logic [11:0] r;
    exp_t       e;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy; sticky_clr = clr;
    #1;
    if (!rst) chk("in_ready", in_ready, (q.size() < 2) || ordy);
    fire_in  = v && in_ready;
    fire_out = out_valid && ordy;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      m_cnt = '0; m_sovf = 1'b0; m_scar = 1'b0; last_merged = -1;
      last_acc = 1'b0;
    end else begin
      if (fire_out) begin
        void'(q.pop_front());
        m_cnt++;
        popped++;
      end
      if (fire_in) begin
        r = alu_ref(a, b, op);
        e.y = r[7:0]; e.f = r[11:8]; e.ill = (op > 3'd4); e.id = next_id++; e.edge_acc = edge_n;
        q.push_back(e);
      end
      if (clr) begin m_sovf = 1'b0; m_scar = 1'b0; end
      if (q.size() > 0 && edge_n > q[0].edge_acc && q[0].id != last_merged) begin
        if (!q[0].ill) begin
          m_sovf = m_sovf | q[0].f[3];
          m_scar = m_scar | q[0].f[2];
        end
        last_merged = q[0].id;
      end
      last_acc = fire_in;
    end
    @(negedge clk);
    check_outputs();
  endtask

  logic [7:0] ys [4];
  logic [7:0] held_y;
  int         acc_n, base_pop;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_out_y", out_y, 8'h00);

    // First ADD: visible on ALU after the accepting edge, on out_* one edge later.
    step(1'b1, 8'd1, 8'd2, 3'd0, 1'b1, 1'b0);
    chk("add_acc", last_acc, 1'b1);
    chk("add_alu_a", alu_a, 8'd1);
    chk("add_alu_b", alu_b, 8'd2);
    chk("add_out_valid_early", out_valid, 1'b0);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
    chk("add_y", out_y, 8'd3);
    chk("add_flags", out_flags, 4'b0000);
    chk("add_cnt_before", result_count, 16'd0);
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0);
    chk("add_cnt_after", result_count, 16'd1);

    // Back-to-back SUB/AND/OR/XOR with no bubbles.
    ys[0] = 8'h07; ys[1] = 8'h00; ys[2] = 8'hFF; ys[3] = 8'h55;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: step(1'b1, 8'd10, 8'd3, 3'd1, 1'b1, 1'b0);
        1: step(1'b1, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b0);
        2: step(1'b1, 8'hFF, 8'h00, 3'd3, 1'b1, 1'b0);
        3: step(1'b1, 8'hAA, 8'hFF, 3'd4, 1'b1, 1'b0);
        default: step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
      endcase
      if (i < 4) chk("b2b_acc", last_acc, 1'b1);
      if (i >= 1 && i <= 4) chk("b2b_y", out_y, ys[i-1]);
      if (i == 2) chk("b2b_zero", out_flags[1], 1'b1);
      if (i == 3) chk("b2b_neg", out_flags[0], 1'b1);
    end

    // Overflow, carry, clear-vs-set collision, lone clear.
    step(1'b1, 8'h7F, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    chk("ovf_y", out_y, 8'h80);
    chk("ovf_flags", out_flags, 4'b1001);
    chk("ovf_sticky", sticky_ovf, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    chk("car_y", out_y, 8'h00);
    chk("car_flags", out_flags, 4'b0110);
    chk("car_sticky", sticky_carry, 1'b1);
    step(1'b1, 8'hFF, 8'h02, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    chk("clrset_carry", sticky_carry, 1'b1);
    chk("clrset_ovf", sticky_ovf, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
    chk("clr_carry", sticky_carry, 1'b0);
    chk("clr_ovf", sticky_ovf, 1'b0);

    // Backpressure: three offered, two accepted, then all three drain in order.
    acc_n = 0; base_pop = popped;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd20 + 8'(acc_n), 8'd5, 3'd0, 1'b0, 1'b0);
      if (last_acc) acc_n++;
    end
    chk("bp_accepted", acc_n, 2);
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    held_y = out_y;
    step(1'b1, 8'd20 + 8'(acc_n), 8'd5, 3'd0, 1'b0, 1'b0);
    chk("bp_y_stable", out_y, held_y);
    for (int i = 0; i < 10 && (acc_n < 3 || q.size() > 0); i++) begin
      step(acc_n < 3, 8'd20 + 8'(acc_n), 8'd5, 3'd0, 1'b1, 1'b0);
      if (last_acc) acc_n++;
    end
    chk("bp_drained", popped - base_pop, 3);

    // Reserved opcode: flagged illegal, sticky unaffected despite ALU flags.
    step(1'b1, 8'h12, 8'h34, 3'd6, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    chk("rsv_illegal", out_illegal, 1'b1);
    chk("rsv_flags_ovf", out_flags[3], 1'b1);
    chk("rsv_sticky_ovf", sticky_ovf, 1'b0);
    chk("rsv_sticky_carry", sticky_carry, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);

    // Reset with both stages full.
    step(1'b1, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_sticky", sticky_ovf, 1'b1);
    rst = 1'b1;
    step(1'b1, 8'h33, 8'h33, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_cnt", result_count, 16'd0);
    chk("rst2_sticky", {sticky_ovf, sticky_carry}, 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    end
    chk("final_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
